// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrating multiplexer family.
// Mode encodings, default width and small index helpers.
package mux_pkg;

    localparam int MUX_MODE_SEL  = 0;
    localparam int MUX_MODE_PRIO = 1;
    localparam int MUX_MODE_RR   = 2;

    localparam int MUX_WIDTH_DEFAULT = 32;

    // Next round-robin start position after index idx was served.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Rotating-priority arbiter: first requester at or after ptr, modulo N.
// Tying ptr to zero turns it into a lowest-index-wins priority arbiter.
module rr_arbiter_n #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_vld,
    output logic [SW-1:0] gnt_idx
);

    int idx;

    // Scan from the far end so the closest requester to ptr wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-input arbitrating multiplexer with a one-entry valid/ready output register.
// Source chosen by external select, fixed priority or round-robin.
module mux_arb_n
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEFAULT,
    parameter int N     = 4,
    parameter int MODE  = MUX_MODE_SEL,
    parameter int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SW-1:0]      sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int NP = 1 << SW;

    logic [SW-1:0]    rr_ptr;
    logic [SW-1:0]    arb_ptr;
    logic             arb_vld;
    logic [SW-1:0]    arb_idx;
    logic [NP-1:0]    vld_ext;
    logic             sel_vld;
    logic             gnt_vld;
    logic [SW-1:0]    gnt_idx;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] gnt_data;

    assign arb_ptr = (MODE == MUX_MODE_RR) ? rr_ptr : '0;

    rr_arbiter_n #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (arb_ptr),
        .gnt_vld (arb_vld),
        .gnt_idx (arb_idx)
    );

    // Pad valids to a power of two so an out-of-range sel reads a zero.
    always_comb begin
        vld_ext           = '0;
        vld_ext[N-1:0]    = in_valid;
        sel_vld           = (int'(sel) < N) && vld_ext[sel];
        if (MODE == MUX_MODE_SEL) begin
            gnt_vld = sel_vld;
            gnt_idx = sel;
        end else begin
            gnt_vld = arb_vld;
            gnt_idx = arb_idx;
        end
    end

    assign load_en  = !out_valid || out_ready;
    assign xfer     = !reset && load_en && gnt_vld;
    assign in_ready = xfer ? (N'(1) << gnt_idx) : '0;
    assign gnt_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_src   <= gnt_idx;
            rr_ptr    <= SW'(wrap_inc(int'(gnt_idx), N));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: four instances (RR4, PRIO4, SEL4, RR3) checked
// against a cycle model with a scoreboard queue of expected output words.
module tb_mux_arb_n;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]   vld  [4];
    logic [127:0] dat  [4];
    logic [1:0]   sel  [4];
    logic         ordy [4];
    logic [3:0]   rdy  [4];
    logic [31:0]  odat [4];
    logic [1:0]   osrc [4];
    logic         oval [4];
    logic [3:0]   r0, r1, r2;
    logic [2:0]   r3;

    assign rdy[0] = r0;
    assign rdy[1] = r1;
    assign rdy[2] = r2;
    assign rdy[3] = {1'b0, r3};

    mux_arb_n #(.WIDTH(32), .N(4), .MODE(MUX_MODE_RR)) u_rr4 (
        .clk(clk), .reset(reset), .in_data(dat[0]), .in_valid(vld[0]),
        .in_ready(r0), .sel(sel[0]), .out_data(odat[0]), .out_src(osrc[0]),
        .out_valid(oval[0]), .out_ready(ordy[0]));

    mux_arb_n #(.WIDTH(32), .N(4), .MODE(MUX_MODE_PRIO)) u_pr4 (
        .clk(clk), .reset(reset), .in_data(dat[1]), .in_valid(vld[1]),
        .in_ready(r1), .sel(sel[1]), .out_data(odat[1]), .out_src(osrc[1]),
        .out_valid(oval[1]), .out_ready(ordy[1]));

    mux_arb_n #(.WIDTH(32), .N(4), .MODE(MUX_MODE_SEL)) u_sel4 (
        .clk(clk), .reset(reset), .in_data(dat[2]), .in_valid(vld[2]),
        .in_ready(r2), .sel(sel[2]), .out_data(odat[2]), .out_src(osrc[2]),
        .out_valid(oval[2]), .out_ready(ordy[2]));

    mux_arb_n #(.WIDTH(32), .N(3), .MODE(MUX_MODE_RR)) u_rr3 (
        .clk(clk), .reset(reset), .in_data(dat[3][95:0]),
        .in_valid(vld[3][2:0]), .in_ready(r3), .sel(sel[3]),
        .out_data(odat[3]), .out_src(osrc[3]),
        .out_valid(oval[3]), .out_ready(ordy[3]));

    typedef struct {
        int         u;
        logic [3:0] vld;
        logic [1:0] sel;
        logic       ordy;
        logic [3:0] rdy;
    } vec_t;

    typedef struct {
        int          u;
        logic [1:0]  src;
        logic [31:0] data;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    int          nch [4] = '{4, 4, 4, 3};
    int          md  [4] = '{2, 1, 0, 2};
    logic        mval[4];
    logic [31:0] mdat[4];
    logic [1:0]  msrc[4];
    int          mptr[4];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    function automatic int mgnt(input int u);
        int s;
        int i;
        if (md[u] == 0) begin
            s = int'(sel[u]);
            if (s < nch[u] && vld[u][s]) return s;
            return -1;
        end
        s = (md[u] == 2) ? mptr[u] : 0;
        for (int k = 0; k < nch[u]; k++) begin
            i = (s + k) % nch[u];
            if (vld[u][i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 4; u++) begin
            mval[u] = 1'b0;
            mdat[u] = '0;
            msrc[u] = '0;
            mptr[u] = 0;
        end
        sb.delete();
    endtask

    task automatic idle();
        for (int u = 0; u < 4; u++) begin
            vld[u]  = '0;
            sel[u]  = '0;
            ordy[u] = 1'b1;
        end
    endtask

    task automatic cyc();
        int         g  [4];
        bit         xf [4];
        logic [3:0] er;
        exp_t       e;
        #1;
        for (int u = 0; u < 4; u++) begin
            g[u]  = mgnt(u);
            xf[u] = (!mval[u] || ordy[u]) && (g[u] >= 0);
            er    = xf[u] ? 4'(1 << g[u]) : 4'd0;
            chk($sformatf("in_ready[%0d]", u), 32'(rdy[u]), 32'(er));
            if (xf[u]) begin
                e.u    = u;
                e.src  = 2'(g[u]);
                e.data = dat[u][g[u]*32 +: 32];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            if (xf[u]) begin
                e       = sb.pop_front();
                mval[u] = 1'b1;
                mdat[u] = e.data;
                msrc[u] = e.src;
                mptr[u] = (g[u] == nch[u] - 1) ? 0 : g[u] + 1;
            end else if (mval[u] && ordy[u]) begin
                mval[u] = 1'b0;
            end
            chk($sformatf("out_valid[%0d]", u), 32'(oval[u]), 32'(mval[u]));
            chk($sformatf("out_data[%0d]", u), odat[u], mdat[u]);
            chk($sformatf("out_src[%0d]", u), 32'(osrc[u]), 32'(msrc[u]));
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            for (int u = 0; u < 4; u++) begin
                chk($sformatf("rst_ready[%0d]", u), 32'(rdy[u]), 32'd0);
                chk($sformatf("rst_valid[%0d]", u), 32'(oval[u]), 32'd0);
                chk($sformatf("rst_data[%0d]", u), odat[u], 32'd0);
            end
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic add(input int u, input logic [3:0] v, input logic [1:0] s,
                       input logic o, input logic [3:0] r);
        vec_t t;
        t.u = u; t.vld = v; t.sel = s; t.ordy = o; t.rdy = r;
        tbl.push_back(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int u = 0; u < 4; u++)
            for (int i = 0; i < 4; i++)
                dat[u][i*32 +: 32] = (u == 0) ? 32'hA0A0_0000 + i
                                              : 32'h1111_1111 * i;
        dat[2][64 +: 32] = 32'hDEAD_BEEF;

        // Round-robin 4: grants 0,1,2,3,0 right after reset
        add(0, 4'hF, 2'd0, 1'b1, 4'b0001);
        add(0, 4'hF, 2'd0, 1'b1, 4'b0010);
        add(0, 4'hF, 2'd0, 1'b1, 4'b0100);
        add(0, 4'hF, 2'd0, 1'b1, 4'b1000);
        add(0, 4'hF, 2'd0, 1'b1, 4'b0001);
        // Fixed priority: ch1 always beats ch3
        add(1, 4'b1010, 2'd0, 1'b1, 4'b0010);
        add(1, 4'b1010, 2'd0, 1'b1, 4'b0010);
        add(1, 4'b1010, 2'd0, 1'b1, 4'b0010);
        // External select, including a selected-but-idle channel
        add(2, 4'b0001, 2'd0, 1'b1, 4'b0001);
        add(2, 4'b0001, 2'd2, 1'b1, 4'b0000);
        add(2, 4'b0101, 2'd2, 1'b1, 4'b0100);
        add(2, 4'b0101, 2'd3, 1'b1, 4'b0000);
        add(2, 4'b0101, 2'd0, 1'b1, 4'b0001);
        // Round-robin 3: pointer wraps from 2 back to 0
        add(3, 4'b0100, 2'd0, 1'b1, 4'b0100);
        add(3, 4'b0101, 2'd0, 1'b1, 4'b0001);
        add(3, 4'b0101, 2'd0, 1'b1, 4'b0100);
        add(3, 4'b0101, 2'd0, 1'b1, 4'b0001);

        idle();
        vld[0] = 4'hF;
        do_reset(2);

        foreach (tbl[i]) begin
            idle();
            vld[tbl[i].u]  = tbl[i].vld;
            sel[tbl[i].u]  = tbl[i].sel;
            ordy[tbl[i].u] = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(rdy[tbl[i].u]),
                32'(tbl[i].rdy));
            cyc();
        end

        // Backpressure on the priority instance
        idle();
        vld[1] = 4'b0100;
        cyc();
        for (int k = 0; k < 5; k++) begin
            ordy[1] = 1'b0;
            vld[1]  = 4'($urandom_range(1, 15));
            dat[1]  = {$urandom, $urandom, $urandom, $urandom};
            cyc();
            chk("stall_src", 32'(osrc[1]), 32'd2);
        end
        ordy[1] = 1'b1;
        vld[1]  = 4'b0001;
        cyc();
        chk("reload_valid", 32'(oval[1]), 32'd1);
        chk("reload_src", 32'(osrc[1]), 32'd0);

        // Reset while a stalled word is held
        idle();
        vld[0] = 4'b0100;
        cyc();
        ordy[0] = 1'b0;
        vld[0]  = 4'b0001;
        cyc();
        do_reset(1);
        vld[0] = 4'hF;
        #1;
        chk("post_rst_ready", 32'(rdy[0]), 32'b0001);
        cyc();
        chk("post_rst_data", odat[0], 32'hA0A0_0000);
        idle();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
